// File: rtl/block_bx_tx_if.sv
// Ready/valid point-to-point link: the source drives vld/data, the sink drives rdy.
// A beat transfers on a rising clock edge where vld && rdy.
interface rdy_vld_if #(
  parameter int DATA_W = 32
);
  logic              vld;
  logic              rdy;
  logic [DATA_W-1:0] data;

  modport src (output vld, output data, input rdy);
  modport dst (input vld, input data, output rdy);
endinterface

// File: rtl/block_bx_tx.sv
// Source-side transmitter: a small FIFO whose head is presented on a ready/valid link,
// with a transfer counter and a flush that never disturbs the beat being presented.
module block_bx_tx #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_vld,
  input  logic [DATA_W-1:0]          push_data,
  output logic                       push_rdy,
  input  logic                       flush,
  rdy_vld_if.src                     x,
  output logic [15:0]                xfer_cnt,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [1:0]                 state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [OW-1:0]     occ_q, occ_d;
  logic [15:0]       cnt_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic do_push, do_pop, do_flush;

  // push_rdy is built from registered state only, so it never follows x.rdy.
  assign push_rdy = (occ_q < OW'(DEPTH)) && (state_q != DRAIN);
  assign do_pop   = (occ_q != '0) && x.rdy;
  assign do_flush = flush && (state_q == SEND);
  // A flush in the same cycle as a push discards the pushed word.
  assign do_push  = push_vld && push_rdy && !do_flush;

  assign x.vld     = (occ_q != '0);
  assign x.data    = mem[rd_q];
  assign occupancy = occ_q;
  assign xfer_cnt  = cnt_q;
  assign state_dbg = state_q;

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    occ_d   = occ_q;
    if (do_pop)  rd_d = rd_q + AW'(1);
    if (do_push) wr_d = wr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
    case (state_q)
      IDLE: begin
        if (do_push) state_d = SEND;
      end
      SEND: begin
        // Flush keeps only the presented head; if it leaves this cycle, nothing remains.
        if (do_flush) begin
          wr_d = rd_q + AW'(1);
          if (do_pop) begin
            occ_d   = '0;
            state_d = IDLE;
          end else begin
            occ_d   = OW'(1);
            state_d = DRAIN;
          end
        end else if (occ_d == '0) begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (do_pop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      occ_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      occ_q   <= occ_d;
      if (do_pop) cnt_q <= cnt_q + 16'd1;
    end
  end

  // Payload storage carries no reset; x.data is meaningless while x.vld is low.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= push_data;
  end

endmodule

// File: tb/tb_block_bx_tx.sv
// Directed bench for block_bx_tx: reset, backpressure, streaming, flush,
// counter wrap and asynchronous reset mid-stall.
module tb_block_bx_tx;

  logic        clk;
  logic        rst;
  logic        push_vld;
  logic [31:0] push_data;
  logic        push_rdy;
  logic        flush;
  logic [15:0] xfer_cnt;
  logic [2:0]  occupancy;
  logic [1:0]  state_dbg;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  rdy_vld_if #(.DATA_W(32)) x_if ();

  block_bx_tx #(.DATA_W(32), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .push_vld  (push_vld),
    .push_data (push_data),
    .push_rdy  (push_rdy),
    .flush     (flush),
    .x         (x_if),
    .xfer_cnt  (xfer_cnt),
    .occupancy (occupancy),
    .state_dbg (state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [31:0] w2 [5];
  logic [31:0] w4 [3];
  int          guard;
  logic [31:0] n;

  initial begin
    w2 = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003, 32'h5555_0004};
    w4 = '{32'hF0F0_0000, 32'hF1F1_0001, 32'hF2F2_0002};

    rst = 1'b1; push_vld = 1'b0; push_data = '0; flush = 1'b0; x_if.rdy = 1'b0;
    tick(); tick();
    check("rst_vld",   32'(x_if.vld),  32'd0);
    check("rst_occ",   32'(occupancy), 32'd0);
    check("rst_prdy",  32'(push_rdy),  32'd1);
    check("rst_cnt",   32'(xfer_cnt),  32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    rst = 1'b0;
    tick();

    // 1: single word, receiver ready
    x_if.rdy = 1'b1; push_vld = 1'b1; push_data = 32'hA5A5_0001;
    tick();
    push_vld = 1'b0;
    check("t1_vld",  32'(x_if.vld),  32'd1);
    check("t1_data", x_if.data,      32'hA5A5_0001);
    check("t1_occ1", 32'(occupancy), 32'd1);
    tick();
    check("t1_cnt",  32'(xfer_cnt),  32'd1);
    check("t1_occ0", 32'(occupancy), 32'd0);
    check("t1_idle", 32'(state_dbg), 32'd0);

    // 2: backpressure, five words into a four-deep FIFO
    x_if.rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_vld = 1'b1; push_data = w2[i];
      tick();
    end
    push_data = w2[4];
    check("t2_full_prdy", 32'(push_rdy),  32'd0);
    check("t2_full_occ",  32'(occupancy), 32'd4);
    for (int i = 0; i < 20; i++) begin
      check("t2_hold_data", x_if.data,     w2[0]);
      check("t2_hold_vld",  32'(x_if.vld), 32'd1);
      tick();
    end
    check("t2_hold_occ", 32'(occupancy), 32'd4);
    x_if.rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("t2_out_vld",  32'(x_if.vld), 32'd1);
      check("t2_out_data", x_if.data,     w2[k]);
      tick();
      if (k == 1) push_vld = 1'b0;
    end
    check("t2_cnt",   32'(xfer_cnt),  32'd6);
    check("t2_empty", 32'(x_if.vld),  32'd0);

    // 3: steady push+pop at occupancy 2
    x_if.rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      push_vld = 1'b1; push_data = 32'hC000_0000 + 32'(i);
      tick();
    end
    check("t3_pre_occ", 32'(occupancy), 32'd2);
    x_if.rdy = 1'b1;
    for (int k = 0; k < 10; k++) begin
      push_data = 32'hC000_0002 + 32'(k);
      check("t3_data", x_if.data, 32'hC000_0000 + 32'(k));
      tick();
      check("t3_occ", 32'(occupancy), 32'd2);
    end
    check("t3_cnt", 32'(xfer_cnt), 32'd16);
    push_vld = 1'b0;
    check("t3_tail0", x_if.data, 32'hC000_000A);
    tick();
    check("t3_tail1", x_if.data, 32'hC000_000B);
    tick();
    check("t3_drained", 32'(occupancy), 32'd0);
    check("t3_cnt2",    32'(xfer_cnt),  32'd18);

    // 4: flush with three entries while stalled
    x_if.rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_vld = 1'b1; push_data = w4[i];
      tick();
    end
    push_vld = 1'b0;
    check("t4_pre_occ",   32'(occupancy), 32'd3);
    check("t4_pre_state", 32'(state_dbg), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t4_state", 32'(state_dbg), 32'd2);
    check("t4_occ",   32'(occupancy), 32'd1);
    check("t4_data",  x_if.data,      w4[0]);
    check("t4_prdy",  32'(push_rdy),  32'd0);
    check("t4_vld",   32'(x_if.vld),  32'd1);
    flush = 1'b1; push_vld = 1'b1; push_data = 32'hDEAD_BEEF;
    tick();
    flush = 1'b0; push_vld = 1'b0;
    check("t4_reflush_occ",  32'(occupancy), 32'd1);
    check("t4_reflush_data", x_if.data,      w4[0]);
    x_if.rdy = 1'b1;
    tick();
    check("t4_cnt",     32'(xfer_cnt),  32'd19);
    check("t4_idle",    32'(state_dbg), 32'd0);
    check("t4_prdy1",   32'(push_rdy),  32'd1);
    check("t4_occ0",    32'(occupancy), 32'd0);
    tick();
    check("t4_one_xfer", 32'(xfer_cnt), 32'd19);

    // 5: counter wrap; word k is pushed as value k so the head after k pops is k
    rst = 1'b1;
    tick();
    rst = 1'b0;
    x_if.rdy = 1'b1; push_vld = 1'b1; n = '0; push_data = n;
    tick();
    n++; push_data = n;
    guard = 0;
    while (xfer_cnt != 16'hFFFE && guard < 70000) begin
      tick();
      n++; push_data = n;
      guard++;
    end
    check("t5_reach",    32'(xfer_cnt), 32'h0000_FFFE);
    check("t5_head",     x_if.data,     32'h0000_FFFE);
    tick();
    check("t5_cnt_ffff", 32'(xfer_cnt), 32'h0000_FFFF);
    tick();
    check("t5_cnt_0000", 32'(xfer_cnt), 32'h0000_0000);
    tick();
    check("t5_cnt_0001", 32'(xfer_cnt), 32'h0000_0001);
    check("t5_occ",      32'(occupancy), 32'd1);

    // 6: asynchronous reset while stalled with two entries
    x_if.rdy = 1'b0; push_vld = 1'b1; push_data = 32'h6666_0000;
    tick();
    push_vld = 1'b0;
    check("t6_pre_occ", 32'(occupancy), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check("t6_vld",   32'(x_if.vld),  32'd0);
    check("t6_occ",   32'(occupancy), 32'd0);
    check("t6_cnt",   32'(xfer_cnt),  32'd0);
    check("t6_prdy",  32'(push_rdy),  32'd1);
    check("t6_state", 32'(state_dbg), 32'd0);
    rst = 1'b0;
    x_if.rdy = 1'b1;
    tick(); tick();
    check("t6_no_xfer", 32'(xfer_cnt), 32'd0);
    check("t6_no_vld",  32'(x_if.vld), 32'd0);

    // final report
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/block_bx_tx.md
# block_bx_tx

Source-side transmitter for the hierIncludeB `rdy_vld_if`; it drives the interface that blockBZ consumes through its `dst` modport. Local producer logic pushes payloads into a small FIFO. The block presents the FIFO head on `x.src` and holds it stable until the receiver accepts it. It also counts completed transfers and supports a flush that discards queued entries without breaking an in-flight handshake.

## Interface
Parameters:
- `DATA_W`, default 32: payload width; must match the `data` field of `rdy_vld_if`.
- `DEPTH`, default 4: FIFO entries; power of two, at least 2.

Ports:
- Clock and reset: one clock. Reset is asynchronous and active-high.
- `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
- `rst`, input, 1 bit: asynchronous, active-high reset.
- `push_vld`, input, 1 bit: the producer offers `push_data`.
- `push_data`, input, `DATA_W` bits: payload offered by the producer.
- `push_rdy`, output, 1 bit: the FIFO can accept a push this cycle.
- `flush`, input, 1 bit: single-cycle pulse that discards all non-presented entries.
- `x`, `rdy_vld_if.src`: drives `x.vld` and `x.data`, samples `x.rdy`.
- `xfer_cnt`, output, 16 bits: number of completed transfers on `x`; wraps.
- `occupancy`, output, `$clog2(DEPTH+1)` bits: current number of FIFO entries.

## Operation
- Push handshake: a push occurs when `push_vld && push_rdy`.
  - `push_rdy = (occupancy < DEPTH) && !draining`.
  - `push_rdy` depends on registered state only; there is no combinational path from `x.rdy`.
- Pop handshake: a pop occurs when `x.vld && x.rdy`.
  - `x.vld = (occupancy != 0)`.
  - `x.data` is the entry at the read pointer.
- Storage: write and read pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`. Occupancy updates as follows:
  - push only: +1.
  - pop only: −1.
  - push and pop in the same cycle: unchanged, both pointers advance.
- Stability rule: while `x.vld && !x.rdy`, `x.data` must not change and `x.vld` must not drop. Flush does not override this rule.
- State machine (2-bit, registered):
  - IDLE (occupancy 0):
    - push → SEND.
    - flush → no effect.
  - SEND (occupancy > 0):
    - pop with no push that leaves occupancy 0 → IDLE.
    - flush with pop this cycle → all entries discarded, occupancy 0 → IDLE.
    - flush without pop → head entry kept, all other entries discarded, occupancy 1 → DRAIN.
  - DRAIN (only the head entry is presented, `push_rdy=0`):
    - pop → IDLE.
    - further flush pulses → ignored.
- Flush and push in the same cycle: the push is not accepted, because `push_rdy` is already low from registered `draining`. If `draining` is still 0 in that cycle, the flush wins: the pushed entry is discarded and the producer must not consider it delivered.
  - Implementation rule: on flush, the write pointer is set to read pointer + 1 (SEND, no pop) or to the read pointer (pop).
- `xfer_cnt` increments on every pop and wraps from 0xFFFF to 0x0000.
- Reset values: state IDLE, pointers 0, `occupancy`=0, `x.vld`=0, `push_rdy`=1, `xfer_cnt`=0.
  - `x.data` is don't-care while `x.vld`=0.
  - Storage is not reset.
- Reset asserted mid-transfer: all outputs return to reset values immediately (asynchronously) and queued data is lost.

## Timing
- Latency: data pushed in cycle N is presentable on `x` in cycle N+1, when the FIFO was empty. There is no combinational push-to-`x` bypass.
- Throughput: one transfer per cycle when the producer and the receiver are both continuously ready.
- Full FIFO with simultaneous pop: `push_rdy` stays 0 that cycle; the push is accepted from the next cycle.
- `occupancy`, `xfer_cnt` and the state update on the clock edge that ends the handshake cycle.
- `x.vld` and `x.data` are driven from registers or the storage read mux only; they never depend on `x.rdy`.

## Test plan
1. Reset, then push 0xA5A5_0001 with `x.rdy`=1. Required: `x.vld`=1 with that data one cycle later, `xfer_cnt`=1 after the edge, `occupancy` back to 0.
2. Backpressure: hold `x.rdy`=0 and push 5 words with `DEPTH`=4. Required:
   - `push_rdy`=0 after the 4th push; the 5th word waits.
   - `x.data` stays equal to the first word for 20 cycles.
   - Releasing `x.rdy` delivers the 5 words in order on 5 consecutive cycles.
3. Simultaneous push and pop at occupancy 2 for 10 cycles. Required: `occupancy` stays 2, in-order data, `xfer_cnt`=10.
4. Flush with 3 entries and `x.rdy`=0. Required:
   - DRAIN, `occupancy`=1, `x.data` equals the oldest entry, `push_rdy`=0.
   - After `x.rdy`=1 there is exactly one transfer, then IDLE with `push_rdy`=1.
5. Preload `xfer_cnt`=0xFFFE via 65534 transfers, then do 3 more transfers. Required: count sequence 0xFFFF, 0x0000, 0x0001.
6. Assert `rst` mid-stall with 2 entries queued. Required: `x.vld`=0 and `occupancy`=0 in the same cycle without a clock edge, and no transfer is counted afterward.
